dvp_pattern_checker: RTL and testbench

- Receive end of the 8-bit parallel camera-style link (pixel clock, 8 data lines, frame_valid, line_valid) driven by the DAQ test-pattern source.
- Oversamples the link in the sys_clk domain, captures one byte per pixel-clock rising edge while both valids are high, and re-emits it as a single-cycle strobed stream.
- Checks captured bytes against the expected mod-256 incrementing pattern, reporting lock state and error counts for link bring-up on the WiFi DAQ board.

---
 rtl/dvp_pattern_checker_if.sv | 11 +
 rtl/dvp_pattern_checker.sv | 181 ++++++++++++++++++
 tb/tb_dvp_pattern_checker.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/dvp_pattern_checker_if.sv
// Parallel camera-style link: pixel clock, 8 data lines, frame and line valid.
// master drives the link (pattern source), slave receives it (checker).
interface dvp_pattern_checker_if;
  logic       pix_clk_in;
  logic [7:0] data_in;
  logic       frame_valid_in;
  logic       line_valid_in;

  modport master (output pix_clk_in, data_in, frame_valid_in, line_valid_in);
  modport slave  (input  pix_clk_in, data_in, frame_valid_in, line_valid_in);
endinterface

// File: rtl/dvp_pattern_checker.sv
// Oversampling receiver for the DAQ test-pattern link: captures one byte per pixel edge
// and checks it against a mod-256 incrementing pattern. Optional watchdog: PIXCLK_TIMEOUT_EN.
module dvp_pattern_checker #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ERR_LIMIT   = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  dvp_pattern_checker_if.slave    link,
  output logic [7:0]              pix_data,
  output logic                    pix_valid,
  output logic                    locked,
  output logic                    err_pulse,
  output logic [CNT_W-1:0]        err_cnt,
  output logic [CNT_W-1:0]        pix_cnt,
  output logic                    clk_lost
);

  localparam int unsigned LW = 11;
  localparam int unsigned CW = $clog2(ERR_LIMIT + 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT_CYC == 0) begin : g_bad_tmo
    $error("TIMEOUT_CYC must be non-zero");
  end

  typedef enum logic [1:0] {IDLE, SEED, CHECK, LOST} state_t;

  // All link lines share one chain so data stays aligned with the pixel clock
  logic [LW-1:0] sync_q [SYNC_STAGES];
  logic [LW-1:0] sync_s;
  logic          pclk_s, fv_s, lv_s;
  logic [7:0]    data_s;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {link.pix_clk_in, link.frame_valid_in, link.line_valid_in, link.data_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign pclk_s = sync_s[10];
  assign fv_s   = sync_s[9];
  assign lv_s   = sync_s[8];
  assign data_s = sync_s[7:0];

  logic       pclk_prev_q, fv_prev_q;
  logic       pix_edge_c, fv_fall_c;
  logic       cap_vld_q;
  logic [7:0] cap_data_q;

  assign pix_edge_c = pclk_s & ~pclk_prev_q;
  assign fv_fall_c  = ~fv_s & fv_prev_q;

  // Capture stage: one byte per qualified pixel edge
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      pclk_prev_q <= 1'b0;
      fv_prev_q   <= 1'b0;
      cap_vld_q   <= 1'b0;
      cap_data_q  <= '0;
    end else begin
      pclk_prev_q <= pclk_s;
      fv_prev_q   <= fv_s;
      cap_vld_q   <= pix_edge_c & fv_s & lv_s;
      if (pix_edge_c && fv_s && lv_s) cap_data_q <= data_s;
    end
  end

  logic tmo_c;

`ifdef PIXCLK_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt_q;
  logic          clk_lost_q;

  // Saturating count of cycles since the last pixel edge, valids ignored
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q  <= '0;
      clk_lost_q <= 1'b0;
    end else if (pix_edge_c) begin
      tmo_cnt_q  <= '0;
      clk_lost_q <= 1'b0;
    end else if (tmo_cnt_q != TW'(TIMEOUT_CYC)) begin
      tmo_cnt_q <= tmo_cnt_q + TW'(1);
      if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) clk_lost_q <= 1'b1;
    end
  end

  assign tmo_c    = clk_lost_q;
  assign clk_lost = clk_lost_q;
`else
  assign tmo_c    = 1'b0;
  assign clk_lost = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [7:0]        exp_q, exp_d;
  logic [CW-1:0]     consec_q, consec_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              err_d;
  logic              err_pulse_q, locked_q, pix_valid_q;
  logic [7:0]        pix_data_q;
  logic [CNT_W-1:0]  pix_cnt_q;

  // Pattern tracker: expected value always follows the last captured byte
  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    consec_d  = consec_q;
    err_cnt_d = err_cnt_q;
    err_d     = 1'b0;
    if (fv_fall_c || tmo_c) begin
      state_d  = IDLE;
      consec_d = '0;
    end else if (cap_vld_q) begin
      exp_d = cap_data_q + 8'd1;
      unique case (state_q)
        IDLE: state_d = SEED;
        SEED: if (cap_data_q == exp_q) state_d = CHECK;
        CHECK: begin
          if (cap_data_q == exp_q) begin
            consec_d = '0;
          end else begin
            err_d    = 1'b1;
            consec_d = consec_q + CW'(1);
            if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + CNT_W'(1);
          end
          if (consec_d == CW'(ERR_LIMIT)) state_d = LOST;
        end
        LOST: begin
          consec_d = '0;
          state_d  = SEED;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      exp_q       <= '0;
      consec_q    <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      pix_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      consec_q    <= consec_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_d;
      locked_q    <= (state_d == CHECK);
      pix_valid_q <= cap_vld_q;
      if (cap_vld_q) begin
        pix_data_q <= cap_data_q;
        pix_cnt_q  <= pix_cnt_q + CNT_W'(1);
      end
    end
  end

  assign pix_data  = pix_data_q;
  assign pix_valid = pix_valid_q;
  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign pix_cnt   = pix_cnt_q;

endmodule

// File: tb/tb_dvp_pattern_checker.sv
// Scoreboard bench for dvp_pattern_checker: the link driver pushes expected responses,
// a forked monitor pops and compares on every pix_valid.
`timescale 1ns/1ps
module tb_dvp_pattern_checker;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned ERR_LIMIT   = 4;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned TIMEOUT_CYC = 1024;

  typedef enum {M_IDLE, M_SEED, M_CHECK, M_LOST} mst_t;
  typedef struct {
    logic [7:0]       d;
    logic             err;
    logic             lk;
    logic [CNT_W-1:0] ec;
    logic [CNT_W-1:0] pc;
  } exp_t;

  logic             sys_clk = 1'b0;
  logic             rst_n   = 1'b0;
  logic [7:0]       pix_data;
  logic             pix_valid, locked, err_pulse, clk_lost;
  logic [CNT_W-1:0] err_cnt, pix_cnt;

  dvp_pattern_checker_if link();

  dvp_pattern_checker #(
    .SYNC_STAGES(SYNC_STAGES), .ERR_LIMIT(ERR_LIMIT),
    .CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .link(link),
    .pix_data(pix_data), .pix_valid(pix_valid), .locked(locked),
    .err_pulse(err_pulse), .err_cnt(err_cnt), .pix_cnt(pix_cnt),
    .clk_lost(clk_lost)
  );

  always #5 sys_clk = ~sys_clk;

  int               checks = 0;
  int               errors = 0;
  exp_t             sb[$];
  mst_t             m_st;
  logic [7:0]       m_exp;
  int               m_consec;
  logic [CNT_W-1:0] m_ec, m_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_exp = '0; m_consec = 0; m_ec = '0; m_pc = '0;
    sb.delete();
  endtask

  // Reference pattern tracker for one captured byte
  task automatic model_byte(input logic [7:0] b);
    exp_t e;
    e.d = b; e.err = 1'b0;
    case (m_st)
      M_IDLE: m_st = M_SEED;
      M_SEED: if (b == m_exp) m_st = M_CHECK;
      M_CHECK: begin
        if (b != m_exp) begin
          e.err = 1'b1;
          m_consec++;
          if (m_ec != {CNT_W{1'b1}}) m_ec = m_ec + CNT_W'(1);
        end else m_consec = 0;
        if (m_consec == ERR_LIMIT) m_st = M_LOST;
      end
      M_LOST: begin m_consec = 0; m_st = M_SEED; end
      default: m_st = M_IDLE;
    endcase
    m_exp = 8'(b + 8'd1);
    m_pc  = m_pc + CNT_W'(1);
    e.lk = (m_st == M_CHECK); e.ec = m_ec; e.pc = m_pc;
    sb.push_back(e);
  endtask

  task automatic monitor();
    logic prev_v = 1'b0;
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (!rst_n) prev_v = 1'b0;
      else if (pix_valid) begin
        chk("pix_valid_back_to_back", 32'(prev_v), 0);
        chk("sb_has_entry", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("pix_data", 32'(pix_data), 32'(e.d));
          chk("err_pulse", 32'(err_pulse), 32'(e.err));
          chk("locked", 32'(locked), 32'(e.lk));
          chk("err_cnt", 32'(err_cnt), 32'(e.ec));
          chk("pix_cnt", 32'(pix_cnt), 32'(e.pc));
        end
        prev_v = 1'b1;
      end else prev_v = 1'b0;
    end
  endtask

  // One pixel period of 20 sys_clk cycles; data set while pix_clk is low
  task automatic send(input logic [7:0] b, input logic lv);
    link.data_in = b;
    link.line_valid_in = lv;
    if (link.frame_valid_in && lv) model_byte(b);
    repeat (10) @(negedge sys_clk);
    link.pix_clk_in = 1'b1;
    repeat (10) @(negedge sys_clk);
    link.pix_clk_in = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pix_data"},  32'(pix_data), 0);
    chk({tag, "_pix_valid"}, 32'(pix_valid), 0);
    chk({tag, "_locked"},    32'(locked), 0);
    chk({tag, "_err_pulse"}, 32'(err_pulse), 0);
    chk({tag, "_err_cnt"},   32'(err_cnt), 0);
    chk({tag, "_pix_cnt"},   32'(pix_cnt), 0);
    chk({tag, "_clk_lost"},  32'(clk_lost), 0);
  endtask

  initial begin
    int cyc;
    link.pix_clk_in = 1'b0; link.data_in = '0;
    link.frame_valid_in = 1'b0; link.line_valid_in = 1'b0;
    model_reset();
    fork monitor(); join_none
    repeat (3) @(negedge sys_clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    link.frame_valid_in = 1'b1; link.line_valid_in = 1'b1;
    repeat (5) @(negedge sys_clk);

    // Clean pattern through the 0xFF -> 0x00 wrap
    for (int i = 0; i < 512; i++) send(8'(i), 1'b1);
    chk("clean_err_cnt", 32'(err_cnt), 0);
    chk("clean_pix_cnt", 32'(pix_cnt), 512);
    chk("clean_locked", 32'(locked), 1);

    // Single glitch: 0x40 replaced by 0x55
    for (int i = 0; i < 64; i++) send(8'(i), 1'b1);
    send(8'h55, 1'b1); send(8'h41, 1'b1); send(8'h42, 1'b1); send(8'h43, 1'b1);
    chk("glitch_err_cnt", 32'(err_cnt), 2);
    chk("glitch_locked", 32'(locked), 1);
    chk("glitch_pix_cnt", 32'(pix_cnt), 580);

    // Loss of lock after four consecutive mismatches, then re-lock
    send(8'h13, 1'b1); send(8'h99, 1'b1); send(8'h07, 1'b1); send(8'hE2, 1'b1);
    chk("lol_err_cnt", 32'(err_cnt), 6);
    chk("lol_locked", 32'(locked), 0);
    send(8'h30, 1'b1); send(8'h31, 1'b1); send(8'h32, 1'b1);
    chk("relock_locked", 32'(locked), 1);
    chk("relock_pix_cnt", 32'(pix_cnt), 587);

    // Line valid low gates capture
    for (int i = 0; i < 10; i++) send(8'(8'hA0 + 8'(i)), 1'b0);
    chk("gated_pix_cnt", 32'(pix_cnt), 587);
    send(8'h33, 1'b1);
    chk("gated_resume_locked", 32'(locked), 1);

    // Frame valid falling drops lock; next frame reseeds
    link.frame_valid_in = 1'b0; m_st = M_IDLE; m_consec = 0;
    repeat (10) @(negedge sys_clk);
    chk("fv_fall_locked", 32'(locked), 0);
    link.frame_valid_in = 1'b1;
    repeat (10) @(negedge sys_clk);
    send(8'h80, 1'b1); send(8'h81, 1'b1);
    chk("reseed_locked", 32'(locked), 1);
    chk("reseed_pix_cnt", 32'(pix_cnt), 590);
    chk("reseed_err_cnt", 32'(err_cnt), 6);

    // Reset asserted mid-frame, between sys_clk edges
    link.data_in = 8'h83;
    link.pix_clk_in = 1'b1;
    @(negedge sys_clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all_zero("midreset");
    link.pix_clk_in = 1'b0;
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);

    // Latency: first sys_clk edge seeing pix_clk high counts as cycle 1
    link.data_in = 8'h20; link.line_valid_in = 1'b1;
    model_byte(8'h20);
    repeat (10) @(negedge sys_clk);
    link.pix_clk_in = 1'b1;
    cyc = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge sys_clk);
      cyc++;
      @(negedge sys_clk);
      if (pix_valid) break;
    end
    chk("latency_cycles", 32'(cyc), SYNC_STAGES + 2);
    repeat (10) @(negedge sys_clk);
    link.pix_clk_in = 1'b0;
    send(8'h21, 1'b1);
    chk("post_reset_locked", 32'(locked), 1);
    chk("post_reset_pix_cnt", 32'(pix_cnt), 2);
    chk("post_reset_err_cnt", 32'(err_cnt), 0);

`ifdef PIXCLK_TIMEOUT_EN
    // Pixel clock stall trips the watchdog
    repeat (TIMEOUT_CYC + 10) @(negedge sys_clk);
    m_st = M_IDLE; m_consec = 0;
    chk("tmo_clk_lost", 32'(clk_lost), 1);
    chk("tmo_locked", 32'(locked), 0);
    send(8'h50, 1'b1);
    chk("tmo_clear_clk_lost", 32'(clk_lost), 0);
    send(8'h51, 1'b1);
    chk("tmo_relock", 32'(locked), 1);
`endif

    repeat (20) @(negedge sys_clk);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
